// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage in-order RV64 pipeline control slice:
// hazard controller FSM state encoding, the default register index width and
// the canonical NOP instruction word loaded into flushed pipeline registers.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Default architectural register index width (32 integer registers)
    localparam int RIDX_W_DEF = 5;

    // addi x0, x0, 0 -- what a flushed IF/ID register holds
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Hazard controller states
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        REDIR   = 2'd1,
        MD_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// -----------------------------------------------------------------------------
// hazard_perf_cnt
// Four free-running wrap-around cycle counters for the hazard controller:
// load-use bubbles, redirect/flush cycles, mul/div wait cycles and data
// memory back-pressure cycles. Each counter increments by one on every
// clock where its *_inc input is high, wraps at 2^CNT_W and is cleared by
// the synchronous active-high reset.
// Only compiled when HAZARD_PERF_EN is defined.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   lu_inc, flush_inc,            per-counter increment strobes
//   md_inc, mem_inc
//   perf_lu_cnt, perf_flush_cnt,  counter registers (CNT_W bits each)
//   perf_md_cnt, perf_mem_cnt
// -----------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_inc,
    input  logic             flush_inc,
    input  logic             md_inc,
    input  logic             mem_inc,
    output logic [CNT_W-1:0] perf_lu_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_md_cnt,
    output logic [CNT_W-1:0] perf_mem_cnt
);

    logic [CNT_W-1:0] lu_cnt_q,    lu_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] md_cnt_q,    md_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q,   mem_cnt_d;

    // Next-count logic: plain modular add, overflow simply wraps
    always_comb begin
        lu_cnt_d    = lu_cnt_q    + CNT_W'(lu_inc);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_inc);
        md_cnt_d    = md_cnt_q    + CNT_W'(md_inc);
        mem_cnt_d   = mem_cnt_q   + CNT_W'(mem_inc);
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
            md_cnt_q    <= '0;
            mem_cnt_q   <= '0;
        end else begin
            lu_cnt_q    <= lu_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            md_cnt_q    <= md_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
        end
    end

    assign perf_lu_cnt    = lu_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_md_cnt    = md_cnt_q;
    assign perf_mem_cnt   = mem_cnt_q;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage in-order RV64 pipeline.
// Resolves, in priority order: data-memory back-pressure (full freeze),
// branch/jump redirect flushes, multi-cycle mul/div waits and load-use
// bubbles. Small FSM (RUN / REDIR / MD_WAIT) plus combinational priority
// logic; no datapath.
//
// Optional feature macro: HAZARD_PERF_EN -- adds four CNT_W-bit performance
// counter outputs (load-use, flush, mul/div wait, mem back-pressure cycles).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1_idx, id_rs2_idx   source register indices of the ID instruction
//   id_use_rs1, id_use_rs2   ID instruction actually reads rs1 / rs2
//   ex_rd_idx, ex_wben       destination / write-back flag of EX instruction
//   ex_is_load               EX instruction is a load
//   ex_redirect              EX resolved a taken control transfer
//   ex_md_start              EX instruction launches multi-cycle mul/div
//   md_done                  mul/div result valid (single-cycle pulse)
//   mem_busy                 data memory stalls the MEM stage
//   pc_en, ifid_en           PC / IF/ID load enables
//   ifid_flush               IF/ID loads a NOP (dominates ifid_en)
//   idex_stall_n             0 = ID/EX loads a bubble
//   idex_hold                ID/EX keeps its contents
//   exmem_bubble             EX/MEM loads a bubble
//   memwb_en                 MEM/WB load enable
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RIDX_W = RIDX_W_DEF
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] id_rs1_idx,
    input  logic [RIDX_W-1:0] id_rs2_idx,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [RIDX_W-1:0] ex_rd_idx,
    input  logic              ex_wben,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic              ex_md_start,
    input  logic              md_done,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_stall_n,
    output logic              idex_hold,
    output logic              exmem_bubble,
    output logic              memwb_en
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_lu_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt,
    output logic [CNT_W-1:0]  perf_md_cnt,
    output logic [CNT_W-1:0]  perf_mem_cnt
`endif
);

    hz_state_e state_q, state_d;
    logic      md_pend_q, md_pend_d;
    logic      lu_haz;

    // Load-use comparator: an in-flight load whose destination is read by
    // the instruction in ID. Writes to x0 are discarded, so never a hazard.
    always_comb begin
        lu_haz = ex_is_load & ex_wben & (ex_rd_idx != '0) &
                 ((id_use_rs1 & (id_rs1_idx == ex_rd_idx)) |
                  (id_use_rs2 & (id_rs2_idx == ex_rd_idx)));
    end

    // Next-state and output logic. Defaults describe a free-flowing pipe;
    // each branch below overrides only what its hazard needs. Back-pressure
    // is checked first because nothing may move while MEM cannot retire;
    // a md_done pulse seen during such a freeze is remembered in md_pend so
    // the mul/div wait can release as soon as the freeze ends.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_stall_n = 1'b1;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        memwb_en     = 1'b1;
        state_d      = state_q;
        md_pend_d    = md_pend_q;

        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_stall_n = 1'b0;
            exmem_bubble = 1'b1;
            memwb_en     = 1'b0;
            state_d      = RUN;
            md_pend_d    = 1'b0;
        end else if (mem_busy) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            memwb_en  = 1'b0;
            idex_hold = 1'b1;
            if (md_done) begin
                md_pend_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    // A redirect kills the younger ID instruction, so any
                    // load-use hazard it carries is irrelevant.
                    if (ex_redirect) begin
                        ifid_flush   = 1'b1;
                        idex_stall_n = 1'b0;
                        state_d      = REDIR;
                    end else if (ex_md_start & ~md_done) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_hold    = 1'b1;
                        exmem_bubble = 1'b1;
                        state_d      = MD_WAIT;
                    end else if (lu_haz) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_stall_n = 1'b0;
                    end
                end
                REDIR: begin
                    // The fetch made in the redirect cycle is stale
                    ifid_flush = 1'b1;
                    state_d    = RUN;
                end
                MD_WAIT: begin
                    if (md_done | md_pend_q) begin
                        md_pend_d = 1'b0;
                        state_d   = RUN;
                    end else begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_hold    = 1'b1;
                        exmem_bubble = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State and pending-done registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            md_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_pend_q <= md_pend_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_bubble;

    // A load-use bubble is only inserted when no higher-priority condition
    // claimed the cycle
    always_comb begin
        lu_bubble = ~rst & ~mem_busy & (state_q == RUN) & ~ex_redirect &
                    ~(ex_md_start & ~md_done) & lu_haz;
    end

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk            (clk),
        .rst            (rst),
        .lu_inc         (lu_bubble),
        .flush_inc      (ifid_flush & ~rst),
        .md_inc         ((state_q == MD_WAIT) & ~rst),
        .mem_inc        (mem_busy & ~rst),
        .perf_lu_cnt    (perf_lu_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_md_cnt    (perf_md_cnt),
        .perf_mem_cnt   (perf_mem_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. A behavioural model of the
// hazard rules runs alongside the DUT and is compared every cycle; directed
// scenarios additionally pin expected output vectors with literal values,
// followed by a randomized run.
// Output vector order: {pc_en, ifid_en, ifid_flush, idex_stall_n,
//                       idex_hold, exmem_bubble, memwb_en}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int RIDX_W = 5;

    localparam logic [6:0] V_DEF    = 7'b1101001;
    localparam logic [6:0] V_RST    = 7'b0010010;
    localparam logic [6:0] V_FREEZE = 7'b0001100;
    localparam logic [6:0] V_REDIRECT = 7'b1110001;
    localparam logic [6:0] V_REDIR  = 7'b1111001;
    localparam logic [6:0] V_MD     = 7'b0001111;
    localparam logic [6:0] V_LU     = 7'b0000001;

    logic              clk = 1'b0;
    logic              rst;
    logic [RIDX_W-1:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
    logic              id_use_rs1, id_use_rs2, ex_wben, ex_is_load;
    logic              ex_redirect, ex_md_start, md_done, mem_busy;
    logic              pc_en, ifid_en, ifid_flush, idex_stall_n;
    logic              idex_hold, exmem_bubble, memwb_en;
    logic [6:0]        outs;
`ifdef HAZARD_PERF_EN
    logic [31:0]       perf_lu_cnt, perf_flush_cnt, perf_md_cnt, perf_mem_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Model state: redirect just happened, waiting on mul/div, done seen early
    bit         m_after_redirect = 1'b0;
    bit         m_md_waiting     = 1'b0;
    bit         m_md_early       = 1'b0;
    logic [6:0] m_exp;
    bit         m_nr, m_nm, m_np;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1_idx   (id_rs1_idx),
        .id_rs2_idx   (id_rs2_idx),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd_idx    (ex_rd_idx),
        .ex_wben      (ex_wben),
        .ex_is_load   (ex_is_load),
        .ex_redirect  (ex_redirect),
        .ex_md_start  (ex_md_start),
        .md_done      (md_done),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_stall_n (idex_stall_n),
        .idex_hold    (idex_hold),
        .exmem_bubble (exmem_bubble),
        .memwb_en     (memwb_en)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_cnt    (perf_lu_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_md_cnt    (perf_md_cnt),
        .perf_mem_cnt   (perf_mem_cnt)
`endif
    );

    assign outs = {pc_en, ifid_en, ifid_flush, idex_stall_n,
                   idex_hold, exmem_bubble, memwb_en};

    always #5 clk = ~clk;

    // One comparison: counts it, reports a FAIL line on disagreement
    task automatic checkOutput(input string name, input logic [6:0] act,
                               input logic [6:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Drives every DUT input in one go
    task automatic applyStimulus(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input bit u1, input bit u2, input logic [4:0] rd,
                                 input bit wb, input bit ld, input bit redir,
                                 input bit mds, input bit mdd, input bit busy);
        rst         = r;
        id_rs1_idx  = rs1;
        id_rs2_idx  = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        ex_rd_idx   = rd;
        ex_wben     = wb;
        ex_is_load  = ld;
        ex_redirect = redir;
        ex_md_start = mds;
        md_done     = mdd;
        mem_busy    = busy;
    endtask

    task automatic idle(input bit r);
        applyStimulus(r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Checks the current cycle against a literal and advances one clock
    task automatic stepAndCheck(input string name, input logic [6:0] exp);
        @(negedge clk);
        checkOutput(name, outs, exp);
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of the hazard rules, highest priority first
    function automatic void modelStep(output logic [6:0] o, output bit nr,
                                      output bit nm, output bit np);
        bit lu;
        lu = ex_is_load && ex_wben && (ex_rd_idx != 0) &&
             ((id_use_rs1 && id_rs1_idx == ex_rd_idx) ||
              (id_use_rs2 && id_rs2_idx == ex_rd_idx));
        nr = m_after_redirect;
        nm = m_md_waiting;
        np = m_md_early;
        if (rst) begin
            o = V_RST; nr = 0; nm = 0; np = 0;
        end else if (mem_busy) begin
            o = V_FREEZE;
            if (md_done) np = 1;
        end else if (m_after_redirect) begin
            o = V_REDIR; nr = 0;
        end else if (m_md_waiting) begin
            if (md_done || m_md_early) begin
                o = V_DEF; nm = 0; np = 0;
            end else begin
                o = V_MD;
            end
        end else if (ex_redirect) begin
            o = V_REDIRECT; nr = 1;
        end else if (ex_md_start && !md_done) begin
            o = V_MD; nm = 1;
        end else if (lu) begin
            o = V_LU;
        end else begin
            o = V_DEF;
        end
    endfunction

    // Every cycle: compare DUT with model, then advance the model
    always @(negedge clk) begin
        modelStep(m_exp, m_nr, m_nm, m_np);
        checkOutput("model", outs, m_exp);
        m_after_redirect <= m_nr;
        m_md_waiting     <= m_nm;
        m_md_early       <= m_np;
    end

    initial begin
        idle(1'b1);
        stepAndCheck("reset0", V_RST);
        stepAndCheck("reset1", V_RST);
        idle(1'b0);
        stepAndCheck("idle", V_DEF);

        // Load x5 in EX, ID reads rs2 = 5: one bubble then free flow
        applyStimulus(0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, 0, 0);
        stepAndCheck("lu_bubble", V_LU);
        idle(1'b0);
        stepAndCheck("lu_after", V_DEF);

        // Load to x0 never stalls
        applyStimulus(0, 5'd0, 5'd3, 1, 0, 5'd0, 1, 1, 0, 0, 0, 0);
        stepAndCheck("lu_x0", V_DEF);

        // Redirect together with a load-use hazard
        applyStimulus(0, 5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 1, 0, 0, 0);
        stepAndCheck("redirect", V_REDIRECT);
        idle(1'b0);
        stepAndCheck("redir_flush", V_REDIR);
        stepAndCheck("redir_done", V_DEF);

        // Mul/div with done eight cycles later
        applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) stepAndCheck("md_wait", V_MD);
        md_done = 1'b1;
        stepAndCheck("md_release", V_DEF);
        idle(1'b0);
        stepAndCheck("md_after", V_DEF);

        // md_done during a freeze is remembered and releases after it
        applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 1, 0, 0);
        stepAndCheck("mdp_start", V_MD);
        stepAndCheck("mdp_wait", V_MD);
        mem_busy = 1'b1; md_done = 1'b1;
        stepAndCheck("mdp_freeze0", V_FREEZE);
        md_done = 1'b0;
        stepAndCheck("mdp_freeze1", V_FREEZE);
        mem_busy = 1'b0;
        stepAndCheck("mdp_release", V_DEF);
        idle(1'b0);
        stepAndCheck("mdp_after", V_DEF);

        // Reset in the middle of a mul/div wait
        applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 1, 0, 0);
        stepAndCheck("rst_md_start", V_MD);
        stepAndCheck("rst_md_wait", V_MD);
        idle(1'b1);
        stepAndCheck("rst_mid", V_RST);
`ifdef HAZARD_PERF_EN
        compared++;
        if ({perf_lu_cnt, perf_flush_cnt, perf_md_cnt, perf_mem_cnt} !== '0) begin
            mismatched++;
            $display("[TB] FAIL perf_clear: got %0d %0d %0d %0d, expected all 0",
                     perf_lu_cnt, perf_flush_cnt, perf_md_cnt, perf_mem_cnt);
        end
`endif
        idle(1'b0);
        stepAndCheck("rst_after", V_DEF);
        applyStimulus(0, 5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0, 0, 0);
        stepAndCheck("rst_run_lu", V_LU);

        // Randomized traffic, small index range so collisions are common
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(99, 0) < 2,
                          5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                          5'($urandom_range(3, 0)),
                          $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 40,
                          $urandom_range(99, 0) < 10, $urandom_range(99, 0) < 15,
                          $urandom_range(99, 0) < 15, $urandom_range(99, 0) < 20);
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
